// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl: autonomous rotating "auto" message on HEX5..HEX0 with pause/step/direction.
// Optional macro HEX_SCROLL_SPEED_EN: SW[2:1] selects step period CLK_DIV >> 2*sel (min 2).
//
// state   | meaning
// S_RUN   | prescaler counting, pos steps on each tick
// S_PAUSE | prescaler held at 0, pos steps only on a KEY[2] press
module hex_scroll_ctrl #(
  parameter int CLK_DIV = 50000000,
  parameter int NPOS    = 6
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [2:0] LAST = 3'(NPOS - 1);

  typedef enum logic {S_RUN = 1'b0, S_PAUSE = 1'b1} state_t;

  logic          rst_n;
  state_t        state_q, state_d;
  logic [2:0]    pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d, tc;
  logic [2:0]    k1_sr, k2_sr;
  logic [1:0]    dir_sr;
  logic          pause_pulse, step_pulse, dir_rev, tick, spd_chg;
  logic [6:0]    hex_q [6];
  logic          unused_ok;

  assign rst_n     = KEY[0];
  assign unused_ok = ^{KEY[3], SW[9:1]};

  function automatic logic [2:0] step_pos(input logic [2:0] p, input logic rev);
    if (rev) return (p == 3'd0) ? LAST : p - 3'd1;
    return (p == LAST) ? 3'd0 : p + 3'd1;
  endfunction

  // Digit i shows message entry (i - p) mod NPOS; out-of-range entries are blank.
  function automatic logic [6:0] digit(input int i, input logic [2:0] p);
    logic [3:0] idx;
    idx = 4'(i) + 4'(NPOS) - {1'b0, p};
    if (idx >= 4'(NPOS)) idx = idx - 4'(NPOS);
    case (idx)
      4'd0:    return 7'b0100011;
      4'd1:    return 7'b0000111;
      4'd2:    return 7'b1100011;
      4'd3:    return 7'b0100000;
      default: return 7'b1111111;
    endcase
  endfunction

  // [0] first flop, [1] synchronised value, [2] previous synchronised value
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      k1_sr  <= '1;
      k2_sr  <= '1;
      dir_sr <= '1;
    end else begin
      k1_sr  <= {k1_sr[1:0], KEY[1]};
      k2_sr  <= {k2_sr[1:0], KEY[2]};
      dir_sr <= {dir_sr[0], SW[0]};
    end
  end

  assign pause_pulse = k1_sr[2] & ~k1_sr[1];
  assign step_pulse  = k2_sr[2] & ~k2_sr[1];
  assign dir_rev     = dir_sr[1];

`ifdef HEX_SCROLL_SPEED_EN
  logic [1:0]  spd_s1, spd_s2, spd_prev;
  logic [31:0] per;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      spd_s1   <= '0;
      spd_s2   <= '0;
      spd_prev <= '0;
    end else begin
      spd_s1   <= SW[2:1];
      spd_s2   <= spd_s1;
      spd_prev <= spd_s2;
    end
  end

  assign spd_chg = (spd_s2 != spd_prev);

  always_comb begin
    per = 32'(CLK_DIV) >> {spd_s2, 1'b0};
    if (per < 32'd2) per = 32'd2;
    tc = CW'(per - 32'd1);
  end
`else
  assign spd_chg = 1'b0;
  assign tc      = CW'(CLK_DIV - 1);
`endif

  assign tick = (state_q == S_RUN) && (cnt_q == tc) && !spd_chg;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      pos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        // A pause press landing on the tick cycle wins; no step is taken.
        if (pause_pulse) begin
          state_d = S_PAUSE;
          cnt_d   = '0;
        end else if (tick) begin
          pos_d = step_pos(pos_q, dir_rev);
          cnt_d = '0;
        end else if (spd_chg) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAUSE: begin
        cnt_d = '0;
        if (step_pulse)  pos_d   = step_pos(pos_q, dir_rev);
        if (pause_pulse) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    if (pos_q > LAST) pos_d = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= digit(i, 3'd0);
    end else begin
      for (int i = 0; i < 6; i++) hex_q[i] <= digit(i, pos_q);
    end
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign LEDR = {state_q == S_PAUSE, 6'b0, pos_q};

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: directed scenarios plus random keys/switches against an event-level model.
module tb_hex_scroll_ctrl;

  localparam int CLK_DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY = 4'b1110;
  logic [9:0] SW = '0;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;
  logic [6:0] hexv [6];

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  hex_scroll_ctrl #(.CLK_DIV(CLK_DIV), .NPOS(6)) dut (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .LEDR(LEDR)
  );

  assign hexv[0] = HEX0;
  assign hexv[1] = HEX1;
  assign hexv[2] = HEX2;
  assign hexv[3] = HEX3;
  assign hexv[4] = HEX4;
  assign hexv[5] = HEX5;

  localparam logic [6:0] G_O = 7'b0100011, G_T = 7'b0000111, G_U = 7'b1100011;
  localparam logic [6:0] G_A = 7'b0100000, G_B = 7'b1111111;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] msg_glyph(input int k);
    case (k)
      0: return G_O;
      1: return G_T;
      2: return G_U;
      3: return G_A;
      default: return G_B;
    endcase
  endfunction

  function automatic int adv(input int p, input bit rev);
    return rev ? (p + 5) % 6 : (p + 1) % 6;
  endfunction

  // Event-level model: key/switch histories give press pulses two edges after sampling;
  // a step falls due every CLK_DIV edges spent running since the last (re)start.
  int m_pos = 0, m_hex_pos = 0, m_age = 0;
  bit m_paused = 0;
  bit [2:0] k1_h = '1, k2_h = '1, d_h = '1;
  bit pp, sp, rv;

  always @(posedge CLOCK_50 or negedge KEY[0]) begin
    if (!KEY[0]) begin
      m_pos = 0; m_hex_pos = 0; m_age = 0; m_paused = 0;
      k1_h = '1; k2_h = '1; d_h = '1;
    end else begin
      pp = (k1_h[1] == 1'b0) && (k1_h[2] == 1'b1);
      sp = (k2_h[1] == 1'b0) && (k2_h[2] == 1'b1);
      rv = d_h[1];
      m_hex_pos = m_pos;
      if (!m_paused) begin
        if (pp) m_paused = 1;
        else begin
          m_age++;
          if (m_age == CLK_DIV) begin
            m_pos = adv(m_pos, rv);
            m_age = 0;
          end
        end
      end else begin
        if (sp) m_pos = adv(m_pos, rv);
        if (pp) begin
          m_paused = 0;
          m_age    = 0;
        end
      end
      k1_h = {k1_h[1:0], KEY[1]};
      k2_h = {k2_h[1:0], KEY[2]};
      d_h  = {d_h[1:0], SW[0]};
    end
  end

  always @(negedge CLOCK_50) begin
    if (KEY[0] === 1'b1) begin
      check_val("m_pos", LEDR[2:0], m_pos);
      check_val("m_paused", LEDR[9], m_paused);
      check_val("m_ledr_zero", LEDR[8:3], 0);
      for (int i = 0; i < 6; i++)
        check_val($sformatf("m_hex%0d", i), hexv[i], msg_glyph((i - m_hex_pos + 6) % 6));
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Called at posedge+1: reset is asserted mid-cycle and must show on the outputs at once.
  task automatic async_reset(input int hold);
    #2 KEY[0] = 1'b0;
    #1;
    check_val("rst_ledr", LEDR, 0);
    for (int i = 0; i < 6; i++) check_val($sformatf("rst_hex%0d", i), hexv[i], msg_glyph(i));
    @(posedge CLOCK_50);
    #1;
    tick_n(hold);
    KEY[0] = 1'b1;
  endtask

  int k1_hold = 0, k2_hold = 0;

  initial begin
    KEY = 4'b1110;
    SW  = '0;
    tick_n(3);
    KEY[0] = 1'b1;

    // Forward rotation: steps at edges 4 and 8 after release, HEX one edge later.
    tick_n(10);
    check_val("fwd_pos", LEDR[2:0], 2);
    check_val("fwd_hex5", HEX5, G_A);
    check_val("fwd_hex4", HEX4, G_U);
    check_val("fwd_hex3", HEX3, G_T);
    check_val("fwd_hex2", HEX2, G_O);
    check_val("fwd_hex1", HEX1, G_B);
    check_val("fwd_hex0", HEX0, G_B);

    // Reverse from reset: first step lands on position 5.
    SW[0] = 1'b1;
    async_reset(1);
    tick_n(6);
    check_val("rev_pos", LEDR[2:0], 5);
    check_val("rev_hex0", HEX0, G_T);
    check_val("rev_hex1", HEX1, G_U);
    check_val("rev_hex2", HEX2, G_A);
    check_val("rev_hex5", HEX5, G_O);

    // Reset mid-count at position 4, then first step exactly 4 edges after release.
    SW[0] = 1'b0;
    async_reset(1);
    tick_n(18);
    check_val("mid_pos4", LEDR[2:0], 4);
    async_reset(1);
    tick_n(3);
    check_val("post_rst_hold", LEDR[2:0], 0);
    tick_n(1);
    check_val("post_rst_step", LEDR[2:0], 1);

    // Pause press landing on the tick edge: no step, pause entered.
    async_reset(1);
    tick_n(1);
    KEY[1] = 1'b0;
    tick_n(3);
    KEY[1] = 1'b1;
    check_val("tick_pause_pos", LEDR[2:0], 0);
    check_val("tick_pause_led", LEDR[9], 1);
    tick_n(40);
    check_val("frozen_pos", LEDR[2:0], 0);
    for (int s = 0; s < 3; s++) begin
      KEY[2] = 1'b0;
      tick_n(2);
      KEY[2] = 1'b1;
      tick_n(3);
    end
    check_val("three_steps", LEDR[2:0], 3);
    KEY[1] = 1'b0;
    tick_n(1);
    KEY[1] = 1'b1;
    tick_n(5);
    check_val("resume_run", LEDR[9], 0);
    check_val("resume_hold", LEDR[2:0], 3);
    tick_n(1);
    check_val("resume_step", LEDR[2:0], 4);

    // Random keys, direction, speed bits and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (k1_hold > 0) begin
        k1_hold--;
        if (k1_hold == 0) KEY[1] = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        KEY[1]  = 1'b0;
        k1_hold = $urandom_range(1, 4);
      end
      if (k2_hold > 0) begin
        k2_hold--;
        if (k2_hold == 0) KEY[2] = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        KEY[2]  = 1'b0;
        k2_hold = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 59) == 0) SW[0] = ~SW[0];
      if ($urandom_range(0, 99) == 0) SW[9:1] = 9'($urandom);
      KEY[3] = 1'($urandom);
      if ($urandom_range(0, 499) == 0) async_reset($urandom_range(0, 2));
      else tick_n(1);
    end

    tick_n(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
